// File: rtl/dsp_mac_acc.sv
// dsp_mac_acc: pre-adder -> multiplier -> block accumulator with a valid-qualified pipeline.
// Define DSP_MAC_SATURATE_EN to clamp the block sum to all-ones once it overflows.
module dsp_mac_acc #(
  parameter int A_W   = 18,
  parameter int B_W   = 18,
  parameter int P_W   = 48,
  parameter int LEN_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             in_valid,
  input  logic [A_W-1:0]   A,
  input  logic [B_W-1:0]   B,
  input  logic [B_W-1:0]   D,
  input  logic             USE_PRE,
  input  logic             PRE_SUB,
  input  logic [P_W-1:0]   C,
  input  logic [LEN_W-1:0] acc_len,
  input  logic             acc_clr,
  output logic             out_valid,
  output logic [P_W-1:0]   P,
  output logic             CARRY_OUT,
  output logic             busy
);
  localparam int M_W    = A_W + B_W;
  localparam int STAGES = 2;

  typedef enum logic {IDLE, ACCUM} state_t;

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
  } s1_t;

  // vld_pipe[1] qualifies s1, vld_pipe[2] qualifies m2
  logic [STAGES:1] vld_pipe;
  s1_t             s1;
  logic [M_W-1:0]  m2;
  logic [B_W-1:0]  pre_sum;
  logic [B_W-1:0]  b_sel;

  state_t          state, state_nxt;
  logic [P_W-1:0]  acc, acc_nxt;
  logic            carry, carry_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic [LEN_W-1:0] len, len_nxt;
  logic            emit_pend, emit_nxt;

  logic            start;
  logic [P_W-1:0]  m_ext;
  logic [P_W-1:0]  add_base;
  logic [P_W:0]    sum;
  logic            carry_sum;
  logic [P_W-1:0]  acc_sum;
  logic [LEN_W-1:0] len_in;
  logic [LEN_W-1:0] cnt_inc;

  // ---------------- S1 / S2 ----------------
  always_comb begin
    pre_sum = PRE_SUB ? (D - B) : (D + B);
    b_sel   = USE_PRE ? pre_sum : B;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1       <= '0;
      m2       <= '0;
      vld_pipe <= '0;
    end else if (CE) begin
      if (in_valid) begin
        s1.a <= A;
        s1.b <= b_sel;
      end
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      m2       <= {{B_W{1'b0}}, s1.a} * {{A_W{1'b0}}, s1.b};
    end
  end

  // ---------------- S3 adder ----------------
  always_comb begin
    m_ext     = P_W'(m2);
    // acc_clr turns a coincident product into the first one of a fresh block
    start     = vld_pipe[STAGES] & ((state == IDLE) | acc_clr);
    add_base  = start ? C : acc;
    sum       = {1'b0, add_base} + {1'b0, m_ext};
    carry_sum = start ? sum[P_W] : (carry | sum[P_W]);
`ifdef DSP_MAC_SATURATE_EN
    acc_sum   = carry_sum ? {P_W{1'b1}} : sum[P_W-1:0];
`else
    acc_sum   = sum[P_W-1:0];
`endif
    len_in    = (acc_len == '0) ? LEN_W'(1) : acc_len;
    cnt_inc   = cnt + LEN_W'(1);
  end

  // ---------------- S3 FSM ----------------
  always_ff @(posedge CLK) begin
    if (RST)     state <= IDLE;
    else if (CE) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    carry_nxt = carry;
    cnt_nxt   = cnt;
    len_nxt   = len;
    emit_nxt  = 1'b0;
    if (acc_clr) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
    if (start) begin
      acc_nxt   = acc_sum;
      carry_nxt = carry_sum;
      len_nxt   = len_in;
      if (len_in == LEN_W'(1)) begin
        emit_nxt  = 1'b1;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end else begin
        cnt_nxt   = LEN_W'(1);
        state_nxt = ACCUM;
      end
    end else if (vld_pipe[STAGES] && state == ACCUM) begin
      acc_nxt   = acc_sum;
      carry_nxt = carry_sum;
      if (cnt_inc == len) begin
        emit_nxt  = 1'b1;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end else begin
        cnt_nxt   = cnt_inc;
      end
    end
  end

  // The finished sum sits in acc for one cycle; a new block may overwrite acc on the same edge P copies it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      len       <= '0;
      emit_pend <= 1'b0;
      out_valid <= 1'b0;
      P         <= '0;
      CARRY_OUT <= 1'b0;
    end else if (CE) begin
      acc       <= acc_nxt;
      carry     <= carry_nxt;
      cnt       <= cnt_nxt;
      len       <= len_nxt;
      emit_pend <= emit_nxt;
      out_valid <= emit_pend;
      if (emit_pend) begin
        P         <= acc;
        CARRY_OUT <= carry;
      end
    end
  end

  assign busy = (state == ACCUM);

endmodule

// File: tb/tb_dsp_mac_acc.sv
// Scoreboard bench for dsp_mac_acc at A_W=B_W=8, P_W=16.
module tb_dsp_mac_acc;
  localparam int A_W = 8, B_W = 8, P_W = 16, LEN_W = 8;

  logic             CLK = 1'b0;
  logic             RST, CE, in_valid, USE_PRE, PRE_SUB, acc_clr;
  logic [A_W-1:0]   A;
  logic [B_W-1:0]   B, D;
  logic [P_W-1:0]   C;
  logic [LEN_W-1:0] acc_len;
  logic             out_valid, CARRY_OUT, busy;
  logic [P_W-1:0]   P;

  dsp_mac_acc #(.A_W(A_W), .B_W(B_W), .P_W(P_W), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .in_valid(in_valid), .A(A), .B(B), .D(D),
    .USE_PRE(USE_PRE), .PRE_SUB(PRE_SUB), .C(C), .acc_len(acc_len), .acc_clr(acc_clr),
    .out_valid(out_valid), .P(P), .CARRY_OUT(CARRY_OUT), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  logic [P_W:0] sb[$];   // {carry, P}
  logic ce_q = 1'b0;
  int   pulses = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [P_W-1:0] p, input logic c);
    sb.push_back({c, p});
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("drain", sb.size(), 0);
  endtask

  task automatic sample(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    in_valid = 1'b1; A = a; B = b;
    tick();
    in_valid = 1'b0;
  endtask

  always @(posedge CLK) ce_q <= CE;

  // a pulse is a new result only if the edge that produced it had CE=1
  always @(negedge CLK) begin
    if (out_valid && ce_q) begin
      logic [P_W:0] e;
      pulses++;
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("P", P, e[P_W-1:0]);
        chk("CARRY_OUT", CARRY_OUT, e[P_W]);
      end
    end
  end

  logic [P_W-1:0] ovf_p;
  int             p0;
  logic           seen;

  initial begin
    RST = 1'b1; CE = 1'b1; in_valid = 1'b1; USE_PRE = 1'b0; PRE_SUB = 1'b0; acc_clr = 1'b0;
    A = '0; B = '0; D = '0; C = '0; acc_len = '0;

    // reset with random activity
    for (int i = 0; i < 2; i++) begin
      A = A_W'($urandom); B = B_W'($urandom); D = B_W'($urandom);
      C = P_W'($urandom); acc_len = LEN_W'($urandom); acc_clr = 1'($urandom);
      tick();
      chk("rst_P", P, 0); chk("rst_ov", out_valid, 0);
      chk("rst_co", CARRY_OUT, 0); chk("rst_busy", busy, 0);
    end
    RST = 1'b0; in_valid = 1'b0; acc_clr = 1'b0;
    tick();
    chk("rel_P", P, 0); chk("rel_ov", out_valid, 0);
    chk("rel_co", CARRY_OUT, 0); chk("rel_busy", busy, 0);

    // block sum with latency check: 10 + 3*6
    C = 10; acc_len = 3;
    push(28, 1'b0);
    in_valid = 1'b1; A = 2; B = 3;
    tick(); tick(); tick();
    in_valid = 1'b0;
    tick(); chk("lat_t3_ov", out_valid, 0); chk("lat_busy", busy, 1);
    tick(); chk("lat_t4_ov", out_valid, 0);
    tick(); chk("lat_t5_ov", out_valid, 1);
    drain();

    // pre-adder, back-to-back single-product blocks
    C = 0; acc_len = 1; USE_PRE = 1'b1; D = 5;
    push(8, 1'b0); push(32, 1'b0);
    PRE_SUB = 1'b1; sample(4, 3);
    PRE_SUB = 1'b0; sample(4, 3);
    USE_PRE = 1'b0;
    drain();

    // overflow, then a clean block shows carry cleared; acc_len=0 acts as 1
`ifdef DSP_MAC_SATURATE_EN
    ovf_p = 16'hFFFF;
`else
    ovf_p = 16'd64514;
`endif
    acc_len = 2; C = 0;
    push(ovf_p, 1'b1);
    sample(255, 255); sample(255, 255);
    drain();
    acc_len = 1; C = 5;
    push(6, 1'b0); sample(1, 1);
    drain();
    acc_len = 0; C = 0;
    push(9, 1'b0); sample(3, 3);
    drain();

    // stall and gap inside a block
    acc_len = 4; C = 0;
    push(4, 1'b0);
    p0 = pulses;
    sample(1, 1); sample(1, 1);
    CE = 1'b0; in_valid = 1'b1;
    tick(); tick(); tick();
    CE = 1'b1; in_valid = 1'b0;
    sample(1, 1);
    tick();
    sample(1, 1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = out_valid;
    end
    chk("stall_ov_seen", seen, 1);
    CE = 1'b0;
    tick(); chk("frz_ov1", out_valid, 1);
    tick(); chk("frz_ov2", out_valid, 1);
    CE = 1'b1;
    tick(); chk("pulse_end", out_valid, 0);
    tick(); tick(); tick();
    chk("stall_pulses", pulses - p0, 1);
    chk("stall_sb", sb.size(), 0);

    // abort via acc_clr coinciding with third product's v2
    C = 0; acc_len = 4;
    push(5, 1'b0);
    in_valid = 1'b1; A = 1; B = 1;
    tick(); tick();
    A = 2; B = 2; tick();
    in_valid = 1'b0;
    tick(); chk("abort_busy", busy, 1);
    acc_clr = 1'b1; C = 1; acc_len = 1;
    tick(); chk("abort_busy_clr", busy, 0);
    acc_clr = 1'b0;
    drain();
    tick(); tick(); tick();

    // same with RST instead of acc_clr
    C = 0; acc_len = 4; p0 = pulses;
    in_valid = 1'b1; A = 1; B = 1;
    tick(); tick();
    A = 2; B = 2; tick();
    in_valid = 1'b0;
    tick();
    RST = 1'b1; C = 1; acc_len = 1;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("rst_mid_P", P, 0);
    chk("rst_mid_co", CARRY_OUT, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_pulses", pulses - p0, 0);
    chk("final_sb", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dsp_mac_acc.md
Name: dsp_mac_acc

Overview:
- Parametrised multiply-accumulate slice; next generation of the team's DSP48A1-style slice.
- Datapath is a pre-adder, then a multiplier, then a post-accumulator, with generic operand and result widths.
- Adds a valid-qualified pipeline and a block accumulator: sums acc_len products onto an offset C, then emits one result pulse.
- Sits between sample sources (FIR taps, correlators) and downstream result consumers.

Parameters:
- A_W, 18, width of A operand (unsigned)
- B_W, 18, width of B and D operands (unsigned)
- P_W, 48, width of C, accumulator and P; must be >= A_W+B_W
- LEN_W, 8, width of acc_len

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous, active-high reset of all state
- CE  in  1  clock enable; 0 freezes every register, counter and output
- in_valid  in  1  A/B/D/USE_PRE/PRE_SUB qualify this cycle
- A  in  A_W  multiplier operand
- B  in  B_W  multiplier/pre-adder operand
- D  in  B_W  pre-adder operand
- USE_PRE  in  1  1: multiplier takes pre-adder result; 0: takes B
- PRE_SUB  in  1  pre-adder mode; 0: D+B, 1: D-B
- C  in  P_W  block offset, sampled with the first product of a block
- acc_len  in  LEN_W  products per block, sampled with the first product; 0 treated as 1
- acc_clr  in  1  abort current block; discard accumulator and counter
- out_valid  out  1  P holds a completed block result
- P  out  P_W  block result
- CARRY_OUT  out  1  sticky carry/overflow of the block accumulation
- busy  out  1  a block is open (state ACCUM)

Behaviour:
- RST (when CE=1, or CE=0; reset has priority over CE): all pipeline registers, counter, accumulator, P, out_valid, CARRY_OUT and busy go to 0; state IDLE. Samples in flight are discarded.
- S1 (in_valid & CE):
  - A1 <= A.
  - B1 <= USE_PRE ? (PRE_SUB ? D-B : D+B) : B, truncated modulo 2^B_W.
  - v1 <= in_valid.
- S2: M <= A1*B1 (A_W+B_W bits, unsigned, zero-extended to P_W); v2 <= v1.
- S3 FSM states IDLE and ACCUM; counter cnt; latched length len.
  - IDLE & v2: acc <= C + M; len <= max(acc_len,1); cnt <= 1; carry <= adder carry. If len==1, go to emit, else go to ACCUM.
  - ACCUM & v2: acc <= acc + M; carry <= carry | adder carry; cnt++. When cnt+1 == len, go to emit.
  - Emit: P <= final sum, CARRY_OUT <= final carry, out_valid <= 1, cnt <= 0, state IDLE.
  - P and CARRY_OUT hold until the next emit or RST.
- out_valid is high for exactly one CE=1 cycle. It stays high while CE=0 freezes it.
- Latency: last sample of a block presented at edge t; P/out_valid valid after edge t+3. Full throughput, one sample per cycle, no backpressure.
- Back-to-back blocks: the sample following the emitting one opens a new block with no bubble.
- Arithmetic: accumulation wraps modulo 2^P_W; carry is the bit P_W of each addition.
- acc_clr (CE=1): next state IDLE, cnt 0, no emit. S1/S2 contents continue through the pipe.
  - If v2 coincides with acc_clr, that product becomes the first product of a new block, using C and acc_len sampled that cycle.
  - acc_clr does not alter P, CARRY_OUT, or an out_valid already asserted.
- in_valid=0 gaps inside a block are allowed; the block stays open indefinitely.
- busy = (state == ACCUM).

Optional Feature:
- Macro DSP_MAC_SATURATE_EN.
- Defined: once a block's carry is set, the accumulator clamps to all-ones and further adds keep it there. The emitted P = 2^P_W-1; CARRY_OUT=1.
- Undefined: wrap-around as above. CARRY_OUT still reports overflow.

Test Plan:
- Reset: RST for 2 cycles with random inputs, in_valid=1 -> P=0, out_valid=0, CARRY_OUT=0, busy=0 throughout and on the first cycle after release.
- Block sum: acc_len=3, C=10, A=2, B=3, USE_PRE=0, 3 consecutive samples at edges t..t+2 -> out_valid only after edge t+5, P=28, CARRY_OUT=0.
- Pre-adder: acc_len=1, C=0, A=4, D=5, B=3, USE_PRE=1, PRE_SUB=1 -> P=8. With PRE_SUB=0 -> P=32.
- Overflow (A_W=B_W=8, P_W=16): acc_len=2, C=0, A=B=255 twice -> P=64514, CARRY_OUT=1. With DSP_MAC_SATURATE_EN defined -> P=65535, CARRY_OUT=1.
- Stall/gap: acc_len=4, A=1, B=1, C=0; CE low 3 cycles mid-block and one in_valid=0 gap -> single out_valid, P=4. Pulse length is one CE=1 cycle.
- Abort/reset mid-block: acc_len=4, 2 samples, then acc_clr coinciding with a third v2 (A=B=2, C=1, acc_len=1) -> next out_valid P=5, no result from aborted block. Repeat with RST in place of acc_clr -> no out_valid, P=0.
